// File: rtl/buzzer_pkg.sv
// buzzer_pkg: shared types and default effect table for buzzer_arbiter.
package buzzer_pkg;
  typedef logic [16:0] half_t;
  typedef enum logic [1:0] {IDLE, MUSIC, SFX, GAP} state_t;
  localparam int DEF_SFX = 4;
  // index 0 explode, 1 pickup, 2 hit, 3 spare
  localparam half_t [DEF_SFX-1:0] SFX_HALF = {17'd50000, 17'd75843, 17'd37922, 17'd113636};
  localparam logic [DEF_SFX-1:0][7:0] SFX_DUR = {8'd10, 8'd15, 8'd8, 8'd30};
endpackage

// File: rtl/buzzer_arbiter_tone_gen.sv
// tone_gen: square wave of a given half-period; idles high, starts low on restart.
module tone_gen
  import buzzer_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  half_t half,
  input  logic  restart,
  input  logic  active,
  output logic  wave
);
  half_t cnt, half_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      half_q <= '0;
      wave <= 1'b1;
    end else begin
      half_q <= half;
      if (!active || half == '0) begin
        cnt <= '0;
        wave <= 1'b1;
      end else if (restart || half != half_q) begin
        cnt <= '0;
        wave <= 1'b0;
      end else if (cnt == half - 17'd1) begin
        cnt <= '0;
        wave <= ~wave;
      end else cnt <= cnt + 17'd1;
    end
endmodule

// File: rtl/buzzer_arbiter.sv
// buzzer_arbiter: shares the board buzzer between background music and prioritised sound effects.
// Define BUZZER_SFX_PREEMPT_EN to let a higher-priority request cut off the playing effect.
module buzzer_arbiter
  import buzzer_pkg::*;
#(
  parameter int NUM_SFX = 4,
  parameter int TICK_DIV = 1_000_000,
  parameter half_t [NUM_SFX-1:0] HALF_TBL = SFX_HALF,
  parameter logic [NUM_SFX-1:0][7:0] DUR_TBL = SFX_DUR
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [NUM_SFX-1:0]         sfx_req,
  input  logic                       music_en,
  input  half_t                      music_half,
  output logic                       Buzzer,
  output logic                       sfx_busy,
  output logic [$clog2(NUM_SFX)-1:0] sfx_idx,
  output logic [NUM_SFX-1:0]         sfx_ack
);
  localparam int IW = $clog2(NUM_SFX);
  localparam int TW = $clog2(TICK_DIV + 1);
  localparam logic [NUM_SFX-1:0] ONE = 1;
  state_t state, nxt;
  logic [NUM_SFX-1:0] pending, win_hot;
  logic [IW-1:0] win, nxt_idx;
  logic [TW-1:0] tcnt;
  logic [7:0] dur;
  logic tick, grant, preempt;
  assign tick = tcnt == TW'(TICK_DIV - 1);
  assign sfx_busy = state == SFX || state == GAP;
  always_comb begin
    win = '0;
    for (int i = NUM_SFX - 1; i >= 0; i--) if (pending[i]) win = IW'(i);
  end
`ifdef BUZZER_SFX_PREEMPT_EN
  assign preempt = state == SFX && |pending && win < sfx_idx;
`else
  assign preempt = 1'b0;
`endif
  always_comb begin
    grant = 1'b0;
    nxt = state;
    if (!en) nxt = IDLE;
    else case (state)
      IDLE, MUSIC: begin
        grant = |pending;
        nxt = music_en ? MUSIC : IDLE;
      end
      SFX: begin
        grant = preempt;
        nxt = tick && dur == 8'd1 ? GAP : SFX;
      end
      default: begin
        grant = tick && |pending;
        nxt = tick ? (music_en ? MUSIC : IDLE) : GAP;
      end
    endcase
    if (grant) nxt = SFX;
  end
  assign win_hot = grant ? ONE << win : '0;
  assign nxt_idx = grant ? win : sfx_idx;
  // tone generator sees next-cycle values so the wave changes on the same edge as the state
  tone_gen u_tone (
    .clk(clk),
    .rst_n(rst_n),
    .half(nxt == SFX ? HALF_TBL[nxt_idx] : music_half),
    .restart(grant || nxt != state),
    .active(nxt == SFX || nxt == MUSIC),
    .wave(Buzzer)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tcnt <= '0;
      state <= IDLE;
      pending <= '0;
      sfx_idx <= '0;
      sfx_ack <= '0;
      dur <= '0;
    end else begin
      tcnt <= tick ? '0 : tcnt + TW'(1);
      state <= nxt;
      pending <= en ? (pending & ~win_hot) | sfx_req : '0;
      sfx_idx <= nxt_idx;
      sfx_ack <= win_hot;
      dur <= grant ? DUR_TBL[win] : (state == SFX && tick) ? dur - 8'd1 : dur;
    end
endmodule
